parking_button_conditioner: RTL and testbench
=============================================

# parking_button_conditioner

Input-conditioning stage directly upstream of the parking meter core. Turns six raw, bouncing push-buttons (four time-add, two preset) into clean single-cycle pulses on the meter's `add1..add4`, `rst1` and `rst2` inputs. Each channel is synchronised, debounced and edge-detected. Add buttons auto-repeat while held. Preset pulses take precedence over add pulses in the same cycle.

## Interface
Parameters:
- `DB_CYCLES`, 3: consecutive identical synchronised samples required to accept a press or a release; legal range 1..255.
- `HOLD_CYCLES`, 100: cycles after the first pulse of a held add button before the first repeat pulse.
- `REPEAT_CYCLES`, 50: cycles between successive repeat pulses.
- `CNT_W`, 16: width of the per-channel hold/repeat counter; must hold max(HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- `clk`  in  1: single clock; the meter's 100 Hz tick domain.
- `rst`  in  1: asynchronous, active-low reset.
- `btn_add1..btn_add4`  in  1 each: raw add buttons, active-high, asynchronous to `clk`.
- `btn_rst1`, `btn_rst2`  in  1 each: raw preset buttons (16 s and 150 s presets), active-high, asynchronous.
- `add1..add4`  out  1 each: one-cycle add pulses to the meter.
- `rst1`, `rst2`  out  1 each: one-cycle preset pulses to the meter.

## Operation
- **Reset:** while `rst` = 0, every output = 0, synchroniser flops = 0, channels in IDLE, all counters = 0.
- **Synchroniser:** each raw input passes through a 2-flop synchroniser; its output is `s`.
- **Channel FSM**, one per button, with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT:
  - IDLE: `s` = 1 → PRESS_WAIT, debounce count = 1.
  - PRESS_WAIT:
    - `s` = 0 → IDLE, count cleared; no pulse.
    - `s` = 1 → count increments. When count reaches DB_CYCLES: emit one pulse, go to HELD, clear the hold counter.
  - HELD:
    - `s` = 0 → RELEASE_WAIT, count = 1.
    - Add channels only: when the hold counter reaches HOLD_CYCLES, emit a pulse. After that, emit a pulse every REPEAT_CYCLES while `s` stays 1.
    - Preset channels never repeat.
  - RELEASE_WAIT:
    - `s` = 1 → HELD, keeping the repeat phase (the hold counter is not cleared); no pulse.
    - `s` = 0 → count increments. At DB_CYCLES → IDLE.
- **Hold counter:** saturates at its terminal value until it is reloaded; it never wraps.
- **Output arbitration** (registered):
  - Any preset pulse in a cycle forces all add outputs to 0 for that cycle. Those add pulses are dropped, not deferred.
  - `rst1` and `rst2` in the same cycle → only `rst2` is output.
  - Several add pulses in the same cycle all pass through (the meter sums them).
- **Mid-operation reset:** asynchronous reset mid-operation clears everything immediately; no pulse is emitted after reset release until a full new press is debounced.

## Timing
- Clean press sampled high at edge k → pulse high for exactly one cycle following edge k + DB_CYCLES + 2. This covers 2 synchroniser flops, the debounce and the output register.
- Repeat: first repeat pulse HOLD_CYCLES cycles after the first pulse; then one every REPEAT_CYCLES cycles.
- Outputs are never high for two consecutive cycles per channel, provided REPEAT_CYCLES ≥ 2.
- Minimum re-press interval: about 2·DB_CYCLES + 2 cycles.

## Structure
- Shared package `parking_pkg` holds:
  - the channel state encoding (2-bit: IDLE = 0, PRESS_WAIT = 1, HELD = 2, RELEASE_WAIT = 3);
  - the channel index constants;
  - the default DB/HOLD/REPEAT values shared with the meter's tick rate.
- Sub-module `button_channel` contains the synchroniser, FSM and counters, with parameter `REPEAT_EN`.
  - Four instances with `REPEAT_EN` = 1 for the add buttons.
  - Two instances with `REPEAT_EN` = 0 for the preset buttons.
- The top level contains only the instances and the registered arbitration.

## Test plan
All scenarios use DB = 3, HOLD = 100, REPEAT = 50.
- **Reset:** hold `rst` low with all buttons high → all outputs 0. Release `rst` with `btn_add1` still high → exactly one `add1` pulse, DB + 2 cycles after the first sampled edge.
- **Bounce:** `btn_add2` toggles 1,0,1,0,1 each cycle, then stays high for 10 cycles → exactly one `add2` pulse, 5 cycles after the stable-high run starts. A release bouncing 0,1,0 → no extra pulse.
- **Auto-repeat:** hold `btn_add3` for 250 cycles → pulses at t0, t0+100, t0+150 and t0+200; none after release. Hold `btn_rst1` for 250 cycles → exactly one `rst1` pulse.
- **Precedence:** `btn_add1`, `btn_add4` and `btn_rst2` pressed on the same edge → only `rst2` pulses. Add `btn_rst1` on the same edge → still only `rst2`.
- **Simultaneous adds:** `btn_add1..btn_add4` pressed together → `add1..add4` all high in the same single cycle.
- **Mid-press reset:** assert `rst` 2 cycles into PRESS_WAIT, deassert with the button still low → no pulse ever.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared constants for the parking meter input stage: channel FSM encoding,
// channel index map and default timing values at the meter's 100 Hz tick.
package parking_pkg;

  // Channel FSM state encoding (2-bit, fixed for compatibility with the meter core)
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  // Channel index map: add buttons occupy the low indices so that the
  // repeating channels form a contiguous slice
  localparam int NUM_CH  = 6;
  localparam int NUM_ADD = 4;
  localparam int CH_ADD1 = 0;
  localparam int CH_ADD2 = 1;
  localparam int CH_ADD3 = 2;
  localparam int CH_ADD4 = 3;
  localparam int CH_RST1 = 4;
  localparam int CH_RST2 = 5;

  // Default timing, in 10 ms ticks
  localparam int DEF_DB_CYCLES     = 3;
  localparam int DEF_HOLD_CYCLES   = 100;
  localparam int DEF_REPEAT_CYCLES = 50;
  localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/parking_button_conditioner_if.sv
// Button/pulse bundle between the front panel and the meter core.
// The conditioner sits on the slave side: it receives raw buttons and
// returns clean one-cycle pulses.
interface parking_button_conditioner_if;

  logic btn_add1;
  logic btn_add2;
  logic btn_add3;
  logic btn_add4;
  logic btn_rst1;
  logic btn_rst2;
  logic add1;
  logic add2;
  logic add3;
  logic add4;
  logic rst1;
  logic rst2;

  modport master (
    output btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
    input  add1, add2, add3, add4, rst1, rst2
  );

  modport slave (
    input  btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
    output add1, add2, add3, add4, rst1, rst2
  );

endinterface

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and hold/repeat
// counter. The pulse output is registered so the top-level arbitration adds
// exactly one more stage of latency.
module button_channel
  import parking_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam logic [7:0]       DB_T   = 8'(DB_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES);

  logic [1:0]       sync_reg;
  logic             s;
  logic [1:0]       state_reg, state_next;
  logic [7:0]       db_cnt_reg, db_cnt_next;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic             phase_reg, phase_next;   // 0: waiting for first repeat, 1: repeating
  logic             pulse_reg, pulse_next;
  logic [7:0]       db_inc;
  logic [CNT_W-1:0] hold_inc;
  logic [CNT_W-1:0] hold_term;

  assign s     = sync_reg[1];
  assign pulse = pulse_reg;

  // Two-flop synchroniser for the asynchronous raw button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= 2'b00;
    else      sync_reg <= {sync_reg[0], btn};
  end

  // Next-state logic: debounce counting, hold/repeat timing and pulse generation
  always_comb begin
    state_next  = state_reg;
    db_cnt_next = db_cnt_reg;
    hold_next   = hold_reg;
    phase_next  = phase_reg;
    pulse_next  = 1'b0;
    db_inc      = db_cnt_reg + 8'd1;
    hold_inc    = hold_reg + CNT_W'(1);
    hold_term   = phase_reg ? REP_T : HOLD_T;
    case (state_reg)
      ST_IDLE: begin
        if (s) begin
          if (DB_T == 8'd1) begin
            // A single sample is enough: accept the press immediately
            state_next  = ST_HELD;
            db_cnt_next = 8'd0;
            hold_next   = '0;
            phase_next  = 1'b0;
            pulse_next  = 1'b1;
          end else begin
            state_next  = ST_PRESS_WAIT;
            db_cnt_next = 8'd1;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_next  = ST_IDLE;
          db_cnt_next = 8'd0;
        end else if (db_inc == DB_T) begin
          state_next  = ST_HELD;
          db_cnt_next = 8'd0;
          hold_next   = '0;
          phase_next  = 1'b0;
          pulse_next  = 1'b1;
        end else begin
          db_cnt_next = db_inc;
        end
      end
      ST_HELD: begin
        if (!s) begin
          if (DB_T == 8'd1) begin
            state_next  = ST_IDLE;
            db_cnt_next = 8'd0;
          end else begin
            state_next  = ST_RELEASE_WAIT;
            db_cnt_next = 8'd1;
          end
        end else if (hold_reg != hold_term) begin
          // Counter saturates at the terminal value unless a repeat reloads it
          hold_next = hold_inc;
          if (REPEAT_EN && (hold_inc == hold_term)) begin
            hold_next  = '0;
            phase_next = 1'b1;
            pulse_next = 1'b1;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          // Bounce during release: resume holding with the repeat phase intact
          state_next  = ST_HELD;
          db_cnt_next = 8'd0;
        end else if (db_inc == DB_T) begin
          state_next  = ST_IDLE;
          db_cnt_next = 8'd0;
        end else begin
          db_cnt_next = db_inc;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        db_cnt_next = 8'd0;
      end
    endcase
  end

  // Channel state, counters and registered pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      db_cnt_reg <= 8'd0;
      hold_reg   <= '0;
      phase_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      db_cnt_reg <= db_cnt_next;
      hold_reg   <= hold_next;
      phase_reg  <= phase_next;
      pulse_reg  <= pulse_next;
    end
  end

endmodule

// File: rtl/parking_button_conditioner.sv
// Six conditioned button channels feeding a registered arbitration stage:
// a preset pulse suppresses all add pulses in the same cycle, and rst2 wins
// over rst1. Simultaneous add pulses all pass through.
module parking_button_conditioner
  import parking_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  parking_button_conditioner_if.slave  bus
);

  logic [NUM_CH-1:0]  btn_vec;
  logic [NUM_CH-1:0]  pulse_vec;
  logic               preset_any;
  logic [NUM_ADD-1:0] add_reg;
  logic               rst1_reg;
  logic               rst2_reg;

  assign btn_vec[CH_ADD1] = bus.btn_add1;
  assign btn_vec[CH_ADD2] = bus.btn_add2;
  assign btn_vec[CH_ADD3] = bus.btn_add3;
  assign btn_vec[CH_ADD4] = bus.btn_add4;
  assign btn_vec[CH_RST1] = bus.btn_rst1;
  assign btn_vec[CH_RST2] = bus.btn_rst2;

  // Add channels (low indices) auto-repeat; preset channels do not
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      button_channel #(
        .DB_CYCLES     (DB_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .CNT_W         (CNT_W),
        .REPEAT_EN     (gi < NUM_ADD)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_vec[gi]),
        .pulse (pulse_vec[gi])
      );
    end
  endgenerate

  assign preset_any = pulse_vec[CH_RST1] | pulse_vec[CH_RST2];

  // Registered arbitration: presets drop same-cycle adds, rst2 beats rst1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_reg  <= '0;
      rst1_reg <= 1'b0;
      rst2_reg <= 1'b0;
    end else begin
      add_reg  <= pulse_vec[NUM_ADD-1:0] & {NUM_ADD{~preset_any}};
      rst1_reg <= pulse_vec[CH_RST1] & ~pulse_vec[CH_RST2];
      rst2_reg <= pulse_vec[CH_RST2];
    end
  end

  assign bus.add1 = add_reg[CH_ADD1];
  assign bus.add2 = add_reg[CH_ADD2];
  assign bus.add3 = add_reg[CH_ADD3];
  assign bus.add4 = add_reg[CH_ADD4];
  assign bus.rst1 = rst1_reg;
  assign bus.rst2 = rst2_reg;

endmodule

// File: tb/tb_parking_button_conditioner.sv
// Directed bench for parking_button_conditioner with DB=3, HOLD=100, REPEAT=50.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_parking_button_conditioner;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  parking_button_conditioner_if bus_if ();

  parking_button_conditioner #(
    .DB_CYCLES     (3),
    .HOLD_CYCLES   (100),
    .REPEAT_CYCLES (50),
    .CNT_W         (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int base;
  int back2back = 0;
  int cnt [6];
  int first_edge [6];
  int add3_times [$];
  int rep_off [4];
  logic [5:0] obs;
  logic [5:0] prev_obs;
  logic [4:0] press_pat;
  logic [2:0] rel_pat;

  // Output vector in channel order {rst2, rst1, add4, add3, add2, add1}
  function automatic logic [5:0] outs();
    return {bus_if.rst2, bus_if.rst1, bus_if.add4, bus_if.add3, bus_if.add2, bus_if.add1};
  endfunction

  task automatic set_btns(input logic [5:0] v);
    bus_if.btn_add1 = v[0];
    bus_if.btn_add2 = v[1];
    bus_if.btn_add3 = v[2];
    bus_if.btn_add4 = v[3];
    bus_if.btn_rst1 = v[4];
    bus_if.btn_rst2 = v[5];
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 6; i++) begin
      cnt[i] = 0;
      first_edge[i] = -1;
    end
    add3_times.delete();
  endtask

  // One clock: count the rising edge, then sample on the falling edge
  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    obs = outs();
    back2back += $countones(obs & prev_obs);
    prev_obs = obs;
    for (int i = 0; i < 6; i++) begin
      if (obs[i]) begin
        cnt[i]++;
        if (first_edge[i] < 0) first_edge[i] = edge_n;
        if (i == 2) add3_times.push_back(edge_n);
      end
    end
  endtask

  function automatic int add3_at(input int k);
    return (add3_times.size() > k) ? add3_times[k] : -1;
  endfunction

  initial begin
    rep_off[0] = 0; rep_off[1] = 100; rep_off[2] = 150; rep_off[3] = 200;
    press_pat = 5'b10101;   // bit i applied on step i: 1,0,1,0,1
    rel_pat   = 3'b010;     // 0,1,0
    prev_obs = 6'b0;
    obs = 6'b0;
    rst = 1'b0;
    set_btns(6'h3F);
    clear_log();

    // Reset held with every button pressed: outputs stay low
    for (int i = 0; i < 4; i++) begin
      step();
      check("reset_outputs_low", int'(obs), 0);
    end

    // Release reset with only add1 still held
    set_btns(6'b000001);
    step();
    rst = 1'b1;
    clear_log();
    base = edge_n + 1;
    repeat (15) step();
    set_btns(6'b000000);
    repeat (15) step();
    check("rst_release_add1_count", cnt[0], 1);
    check("rst_release_add1_edge", first_edge[0], base + 5);
    check("rst_release_other_outputs", cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);

    // Bouncing press on add2, then stable, then bouncing release
    clear_log();
    for (int i = 0; i < 5; i++) begin
      bus_if.btn_add2 = press_pat[i];
      if (i == 4) base = edge_n + 1;
      step();
    end
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      bus_if.btn_add2 = rel_pat[i];
      step();
    end
    bus_if.btn_add2 = 1'b0;
    repeat (15) step();
    check("bounce_add2_count", cnt[1], 1);
    check("bounce_add2_edge", first_edge[1], base + 5);

    // Auto-repeat on add3 held for 250 cycles
    clear_log();
    bus_if.btn_add3 = 1'b1;
    base = edge_n + 1;
    repeat (250) step();
    bus_if.btn_add3 = 1'b0;
    repeat (20) step();
    check("repeat_add3_count", cnt[2], 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("repeat_add3_pulse%0d_edge", k), add3_at(k), base + 5 + rep_off[k]);
    end

    // Preset rst1 held for 250 cycles never repeats
    clear_log();
    bus_if.btn_rst1 = 1'b1;
    base = edge_n + 1;
    repeat (250) step();
    bus_if.btn_rst1 = 1'b0;
    repeat (20) step();
    check("hold_rst1_count", cnt[4], 1);
    check("hold_rst1_edge", first_edge[4], base + 5);

    // add1 + add4 + rst2 on the same edge: only rst2
    clear_log();
    set_btns(6'b101001);
    base = edge_n + 1;
    repeat (10) step();
    set_btns(6'b000000);
    repeat (15) step();
    check("prec_rst2_count", cnt[5], 1);
    check("prec_rst2_edge", first_edge[5], base + 5);
    check("prec_add1_dropped", cnt[0], 0);
    check("prec_add4_dropped", cnt[3], 0);

    // add1 + add4 + rst1 + rst2 on the same edge: still only rst2
    clear_log();
    set_btns(6'b111001);
    base = edge_n + 1;
    repeat (10) step();
    set_btns(6'b000000);
    repeat (15) step();
    check("prec2_rst2_count", cnt[5], 1);
    check("prec2_rst1_suppressed", cnt[4], 0);
    check("prec2_adds_dropped", cnt[0] + cnt[3], 0);

    // All four adds pressed together: all pulse in the same cycle
    clear_log();
    set_btns(6'b001111);
    base = edge_n + 1;
    repeat (10) step();
    set_btns(6'b000000);
    repeat (15) step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("simul_add%0d_count", i + 1), cnt[i], 1);
      check($sformatf("simul_add%0d_edge", i + 1), first_edge[i], base + 5);
    end
    check("simul_presets_quiet", cnt[4] + cnt[5], 0);

    // Reset two cycles into PRESS_WAIT, released with the button low
    clear_log();
    bus_if.btn_add1 = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    bus_if.btn_add1 = 1'b0;
    #1;
    check("midreset_outputs_low", int'(outs()), 0);
    repeat (3) step();
    rst = 1'b1;
    repeat (20) step();
    check("midreset_add1_count", cnt[0], 0);

    check("no_back_to_back_pulses", back2back, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
